// File: rtl/cmd_frm_gen_if.sv
// rtl/cmd_frm_gen_if.sv - command request / response bundle for cmd_frm_gen
interface cmd_frm_gen_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4
);
  logic                     req_valid;
  logic                     req_ready;
  logic [1:0]               req_cmd;
  logic [ADDR_WIDTH-1:0]    req_addr;
  logic [DATA_WIDTH-1:0]    req_wr_data;
  logic [DATA_WIDTH-1:0]    req_op_a;
  logic [DATA_WIDTH-1:0]    req_op_b;
  logic [ALU_FUN_WIDTH-1:0] req_alu_fun;
  logic                     rsp_valid;
  logic [2*DATA_WIDTH-1:0]  rsp_data;
  logic                     rsp_timeout;

  modport master (
    output req_valid, req_cmd, req_addr, req_wr_data, req_op_a, req_op_b, req_alu_fun,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_wr_data, req_op_a, req_op_b, req_alu_fun,
    output req_ready, rsp_valid, rsp_data, rsp_timeout
  );
endinterface

// File: rtl/cmd_frm_gen.sv
// rtl/cmd_frm_gen.sv - builds RF/ALU command frames for a UART and collects the reply
// Optional macro RSP_TIMEOUT_EN enables the response-idle timeout.
module cmd_frm_gen #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_FUN_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  cmd_frm_gen_if.slave          req_if,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  busy,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD
);
  typedef enum logic [2:0] {IDLE, SEND, TX_WAIT_HI, TX_WAIT_LO, RX_WAIT, DONE} state_t;

  state_t                   state, nxt;
  logic [1:0]               cmd_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    wr_q, a_q, b_q;
  logic [ALU_FUN_WIDTH-1:0] fun_q;
  logic [1:0]               idx;
  logic                     rx_cnt;
  logic [2*DATA_WIDTH-1:0]  rsp_q;
  logic [DATA_WIDTH-1:0]    frm_byte;
  logic [1:0]               last_idx;
  logic                     rx_last;
  logic                     accept, tx_fire, idx_adv, rx_take;

`ifdef RSP_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] to_cnt;
  logic          to_fire, to_flag;
`endif

  always_comb begin
    frm_byte = '0;
    last_idx = 2'd1;
    rx_last  = 1'b1;
    case (cmd_q)
      2'd0: begin
        last_idx = 2'd2;
        case (idx)
          2'd0:    frm_byte = DATA_WIDTH'(8'hAA);
          2'd1:    frm_byte = DATA_WIDTH'(addr_q);
          default: frm_byte = wr_q;
        endcase
      end
      2'd1: begin
        rx_last  = 1'b0;
        frm_byte = (idx == 2'd0) ? DATA_WIDTH'(8'hBB) : DATA_WIDTH'(addr_q);
      end
      2'd2: begin
        last_idx = 2'd3;
        case (idx)
          2'd0:    frm_byte = DATA_WIDTH'(8'hCC);
          2'd1:    frm_byte = a_q;
          2'd2:    frm_byte = b_q;
          default: frm_byte = DATA_WIDTH'(fun_q);
        endcase
      end
      default: frm_byte = (idx == 2'd0) ? DATA_WIDTH'(8'hDD) : DATA_WIDTH'(fun_q);
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt     = state;
    accept  = 1'b0;
    tx_fire = 1'b0;
    idx_adv = 1'b0;
    rx_take = 1'b0;
`ifdef RSP_TIMEOUT_EN
    to_fire = 1'b0;
`endif
    case (state)
      IDLE: if (req_if.req_valid) begin
        accept = 1'b1;
        nxt    = SEND;
      end
      SEND: if (!busy) begin
        tx_fire = 1'b1;
        nxt     = TX_WAIT_HI;
      end
      TX_WAIT_HI: if (busy) nxt = TX_WAIT_LO;
      TX_WAIT_LO: if (!busy) begin
        idx_adv = 1'b1;
        if (idx != last_idx)   nxt = SEND;
        else if (cmd_q == 2'd0) nxt = DONE;
        else                    nxt = RX_WAIT;
      end
      RX_WAIT: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (RX_D_VLD) begin
          rx_take = 1'b1;
          if (rx_cnt == rx_last) nxt = DONE;
        end
`ifdef RSP_TIMEOUT_EN
        else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          to_fire = 1'b1;
          nxt     = DONE;
        end
`endif
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cmd_q     <= '0;
      addr_q    <= '0;
      wr_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      fun_q     <= '0;
      idx       <= '0;
      rx_cnt    <= 1'b0;
      rsp_q     <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
    end else begin
      TX_D_VLD <= tx_fire;
      if (accept) begin
        cmd_q  <= req_if.req_cmd;
        addr_q <= req_if.req_addr;
        wr_q   <= req_if.req_wr_data;
        a_q    <= req_if.req_op_a;
        b_q    <= req_if.req_op_b;
        fun_q  <= req_if.req_alu_fun;
        idx    <= '0;
        rx_cnt <= 1'b0;
        rsp_q  <= '0;
      end
      if (tx_fire) TX_P_DATA <= frm_byte;
      if (idx_adv) idx <= idx + 2'd1;
      if (rx_take) begin
        rx_cnt <= 1'b1;
        if (rx_cnt) rsp_q[2*DATA_WIDTH-1:DATA_WIDTH] <= RX_P_DATA;
        else        rsp_q[DATA_WIDTH-1:0]            <= RX_P_DATA;
      end
    end
  end

`ifdef RSP_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (state != RX_WAIT || rx_take) to_cnt <= '0;
      else                             to_cnt <= to_cnt + 1'b1;
      if (accept)       to_flag <= 1'b0;
      else if (to_fire) to_flag <= 1'b1;
    end
  end
  assign req_if.rsp_timeout = (state == DONE) && to_flag;
`else
  assign req_if.rsp_timeout = 1'b0;
`endif

  assign req_if.req_ready = (state == IDLE);
  assign req_if.rsp_valid = (state == DONE);
  assign req_if.rsp_data  = rsp_q;
endmodule
